// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port cache-to-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector for the I/D miss ports.
// ARB_RR_EN selects round-robin; otherwise fixed D-over-I priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last,
    output logic grant
);

`ifdef ARB_RR_EN
    always_comb begin
        grant = d_req ? OWN_D : OWN_I;
        // On a tie, the port that did not win last time goes first.
        if (i_req && d_req) begin
            grant = (last == OWN_D) ? OWN_I : OWN_D;
        end
    end
`else
    logic unused_pick;

    assign unused_pick = i_req ^ last;

    always_comb begin
        grant = d_req ? OWN_D : OWN_I;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache block misses onto one slow_memory channel.
// Optional macro ARB_RR_EN: round-robin instead of fixed D-over-I priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t              state_q;
    state_t              state_d;
    owner_t              owner_q;
    logic                kind_wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                i_req;
    logic                d_req;
    logic                grant;
    logic                last_grant;
    logic                take;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;
    assign take  = (state_q == IDLE) && (i_req || d_req);

    mem_arb_pick u_pick (
        .i_req (i_req),
        .d_req (d_req),
        .last  (last_grant),
        .grant (grant)
    );

`ifdef ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_I;
        end else if (take) begin
            last_grant <= grant;
        end
    end
`else
    assign last_grant = OWN_D;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // Turnaround cycle: lets the requester drop its request before IDLE samples it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_D;
            kind_wr_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                owner_q <= owner_t'(grant);
                if (grant == OWN_D) begin
                    kind_wr_q <= d_write;
                    addr_q    <= d_addr;
                    wdata_q   <= d_wdata;
                end else begin
                    kind_wr_q <= i_write;
                    addr_q    <= i_addr;
                    wdata_q   <= i_wdata;
                end
            end
            // Writes leave the owner's rdata untouched; only reads refresh it.
            if ((state_q == BUSY) && mem_ready && !kind_wr_q) begin
                if (owner_q == OWN_D) begin
                    d_rdata_q <= mem_rdata;
                end else begin
                    i_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_read  = (state_q == BUSY) && !kind_wr_q;
    assign mem_write = (state_q == BUSY) &&  kind_wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = (state_q == RESP) && (owner_q == OWN_I);
    assign d_ready   = (state_q == RESP) && (owner_q == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, i_write, d_read, d_write;
    logic [27:0]   i_addr, d_addr, mem_addr;
    logic [127:0]  i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_ready, d_ready, mem_read, mem_write, mem_ready;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] exp_i_rdata;
    logic [127:0] exp_d_rdata;
    bit           last_is_d;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        last_is_d   = 1'b0;
    endtask

    // Which port the arbitration rule grants, given the current requests.
    function automatic bit pick_d(input bit ri, input bit rq);
        if (!ri) return 1'b1;
        if (!rq) return 1'b0;
`ifdef ARB_RR_EN
        return !last_is_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_mem_read"}, mem_read, 0);
        check_eq({tag, "_mem_write"}, mem_write, 0);
        check_eq({tag, "_i_ready"}, i_ready, 0);
        check_eq({tag, "_d_ready"}, d_ready, 0);
    endtask

    // Entered at the negedge of the first BUSY cycle; leaves at the negedge of RESP.
    task automatic serve(input bit own_d, input bit is_wr, input logic [27:0] a,
                         input logic [127:0] wd, input int lat, input logic [127:0] rdv);
        for (int k = 0; k <= lat; k++) begin
            check_eq("busy_mem_read", mem_read, !is_wr);
            check_eq("busy_mem_write", mem_write, is_wr);
            check_eq("busy_mem_addr", mem_addr, a);
            if (is_wr) check_eq("busy_mem_wdata", mem_wdata, wd);
            check_eq("busy_i_ready", i_ready, 0);
            check_eq("busy_d_ready", d_ready, 0);
            // Requester-side changes while busy must not reach memory.
            if (own_d) begin d_addr = $urandom; d_wdata = rnd128(); end
            else       begin i_addr = $urandom; i_wdata = rnd128(); end
            if (k == lat) begin mem_ready = 1'b1; mem_rdata = rdv; end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = rnd128();
        last_is_d = own_d;
        if (!is_wr) begin
            if (own_d) exp_d_rdata = rdv; else exp_i_rdata = rdv;
        end
        check_eq("resp_i_ready", i_ready, !own_d);
        check_eq("resp_d_ready", d_ready, own_d);
        check_eq("resp_i_rdata", i_rdata, exp_i_rdata);
        check_eq("resp_d_rdata", d_rdata, exp_d_rdata);
        check_eq("resp_mem_read", mem_read, 0);
        check_eq("resp_mem_write", mem_write, 0);
        if (own_d) begin d_read = 0; d_write = 0; end
        else       begin i_read = 0; i_write = 0; end
    endtask

    // kind: 0 read, 1 write, 2 read+write (treated as write)
    task automatic run_round(input bit ri, input bit rq, input int ki, input int kd);
        logic [27:0]  ai, ad;
        logic [127:0] wi, wdd;
        bit           first_d;
        ai = $urandom; ad = $urandom; wi = rnd128(); wdd = rnd128();
        i_addr = ai; i_wdata = wi; d_addr = ad; d_wdata = wdd;
        i_read  = ri && (ki != 1); i_write = ri && (ki != 0);
        d_read  = rq && (kd != 1); d_write = rq && (kd != 0);
        first_d = pick_d(ri, rq);
        @(negedge clk);
        if (first_d) serve(1'b1, kd != 0, ad, wdd, $urandom_range(0, 4), rnd128());
        else         serve(1'b0, ki != 0, ai, wi, $urandom_range(0, 4), rnd128());
        if (ri && rq) begin
            @(negedge clk);
            check_idle("turn");
            @(negedge clk);
            if (first_d) serve(1'b0, ki != 0, ai, wi, $urandom_range(0, 4), rnd128());
            else         serve(1'b1, kd != 0, ad, wdd, $urandom_range(0, 4), rnd128());
        end
        @(negedge clk);
        check_idle("after");
    endtask

    task automatic check_all_zero(input string tag);
        check_idle(tag);
        check_eq({tag, "_mem_addr"}, mem_addr, 0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
        check_eq({tag, "_i_rdata"}, i_rdata, 0);
        check_eq({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    initial begin
        rst = 1'b1;
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Single D read, 5-cycle memory latency.
        d_read = 1; d_addr = 28'h0000010;
        @(negedge clk);
        serve(1'b1, 1'b0, 28'h0000010, '0, 5, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_BEEF);
        check_eq("dread_data", d_rdata, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_BEEF);
        @(negedge clk);
        check_idle("dread_after");

        // I read against D write, four times back to back.
        repeat (4) run_round(1'b1, 1'b1, 0, 1);
        // D read+write together counts as a write.
        run_round(1'b0, 1'b1, 0, 2);

        // Spurious mem_ready while idle.
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check_idle("spur");
        @(negedge clk);
        check_idle("spur2");

        // Reset two cycles into BUSY, then the I read is retried.
        run_round(1'b1, 1'b0, 0, 0);
        i_read = 1; i_addr = 28'h0ABCDEF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all_zero("rst_busy");
        @(negedge clk);
        serve(1'b0, 1'b0, 28'h0ABCDEF, '0, 2, rnd128());
        @(negedge clk);
        check_idle("rst_retry");

        for (int r = 0; r < 60; r++) begin
            int sel;
            sel = $urandom_range(1, 3);
            run_round(sel[0], sel[1], $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
